// File: rtl/dds_regs_pkg.sv
// Shared DDS register map and loader state type, imported by the DDS slave and the loader.
// The read-back state only exists when DDS_LOADER_VERIFY_EN is defined.
package dds_regs_pkg;

  localparam int unsigned ADDR_STEP_BASE = 0;
  localparam int unsigned ADDR_ENABLE    = 16;
  localparam int unsigned ADDR_TIPO      = 17;
  localparam int unsigned ADDR_START     = 18;
  localparam int unsigned ADDR_AUMENTAR  = 19;
  localparam int unsigned ADDR_DISMINUIR = 20;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_WR_TABLE,
    LD_WR_TIPO,
    LD_WR_ENABLE,
    LD_WR_START,
    LD_DONE
`ifdef DDS_LOADER_VERIFY_EN
    , LD_RD_TABLE
`endif
  } loader_state_e;

endpackage

// File: rtl/dds_avalon_mm_loader_if.sv
// Avalon-MM bus between the DDS loader (master) and the DDS register slave.
interface dds_avalon_mm_loader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, chipselect, write, read, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, write, read, writedata,
    output readdata, waitrequest
  );

endinterface

// File: rtl/dds_avm_xfer.sv
// Single Avalon-MM transfer engine: holds strobes/address/data until waitrequest drops,
// and flags a timeout after TIMEOUT consecutive stall cycles.
module dds_avm_xfer #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_c,
  input  logic              issue_read_c,
  input  logic [ADDR_W-1:0] issue_address_c,
  input  logic [DATA_W-1:0] issue_writedata_c,
  output logic              xfer_done_c,
  output logic              xfer_timeout_c,
  dds_avalon_mm_loader_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;

  assign xfer_done_c    = bus.chipselect & ~bus.waitrequest;
  assign xfer_timeout_c = bus.chipselect & bus.waitrequest &
                          (stall_cnt == CNT_W'(TIMEOUT - 1));

  // A new issue always wins; completion or timeout drops the strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.address    <= '0;
      bus.writedata  <= '0;
      bus.chipselect <= 1'b0;
      bus.write      <= 1'b0;
      bus.read       <= 1'b0;
      stall_cnt      <= '0;
    end else if (issue_c) begin
      bus.address    <= issue_address_c;
      bus.writedata  <= issue_read_c ? '0 : issue_writedata_c;
      bus.chipselect <= 1'b1;
      bus.write      <= ~issue_read_c;
      bus.read       <= issue_read_c;
      stall_cnt      <= '0;
    end else if (xfer_done_c || xfer_timeout_c) begin
      bus.chipselect <= 1'b0;
      bus.write      <= 1'b0;
      bus.read       <= 1'b0;
      stall_cnt      <= '0;
    end else if (bus.chipselect) begin
      stall_cnt      <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dds_avalon_mm_loader.sv
// Avalon-MM master that loads the DDS step table, tipo_ajuste and enable, then pulses start.
// Define DDS_LOADER_VERIFY_EN to read back and check the table before enable/start.
module dds_avalon_mm_loader
  import dds_regs_pkg::*;
#(
  parameter int unsigned N_STEPS = 16,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_go,
  input  logic [N_STEPS-1:0][DATA_W-1:0] i_step_table,
  input  logic                           i_enable,
  input  logic                           i_tipo_ajuste,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_error,
  dds_avalon_mm_loader_if.master         avm
);

  localparam int unsigned IDX_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  loader_state_e state, next_state;
  logic [IDX_W-1:0] index, next_index;

  logic [N_STEPS-1:0][DATA_W-1:0] table_q, table_d;
  logic enable_q, enable_d, tipo_q, tipo_d;

  logic              go_accept_c;
  logic              last_index_c;
  logic              issue_c;
  logic              issue_read_c;
  logic [ADDR_W-1:0] issue_address_c;
  logic [DATA_W-1:0] issue_writedata_c;
  logic              xfer_done_c;
  logic              xfer_timeout_c;
  logic              busy_d, done_d, error_d;

  assign go_accept_c  = (state == LD_IDLE) & i_go;
  assign last_index_c = (index == IDX_W'(N_STEPS - 1));

  // Values as they will be held next cycle, so the first write can use fresh inputs.
  assign table_d  = go_accept_c ? i_step_table  : table_q;
  assign enable_d = go_accept_c ? i_enable      : enable_q;
  assign tipo_d   = go_accept_c ? i_tipo_ajuste : tipo_q;

`ifndef DDS_LOADER_VERIFY_EN
  logic unused_readdata;
  assign unused_readdata = ^avm.readdata;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= LD_IDLE;
      index    <= '0;
      table_q  <= '0;
      enable_q <= 1'b0;
      tipo_q   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_error  <= 1'b0;
    end else begin
      state    <= next_state;
      index    <= next_index;
      table_q  <= table_d;
      enable_q <= enable_d;
      tipo_q   <= tipo_d;
      o_busy   <= busy_d;
      o_done   <= done_d;
      o_error  <= error_d;
    end
  end

  // Sequencing: every transfer state advances on completion and aborts on timeout.
  always_comb begin
    next_state = state;
    next_index = index;
    issue_c    = 1'b0;
    error_d    = go_accept_c ? 1'b0 : o_error;

    unique case (state)
      LD_IDLE: begin
        if (i_go) begin
          next_state = LD_WR_TABLE;
          next_index = '0;
          issue_c    = 1'b1;
        end
      end
      LD_DONE: next_state = LD_IDLE;
      default: begin
        if (xfer_timeout_c) begin
          next_state = LD_IDLE;
          next_index = '0;
          error_d    = 1'b1;
        end else if (xfer_done_c) begin
          issue_c = 1'b1;
          unique case (state)
            LD_WR_TABLE: begin
              if (last_index_c) begin
                next_index = '0;
`ifdef DDS_LOADER_VERIFY_EN
                next_state = LD_RD_TABLE;
`else
                next_state = LD_WR_TIPO;
`endif
              end else begin
                next_index = index + IDX_W'(1);
              end
            end
`ifdef DDS_LOADER_VERIFY_EN
            LD_RD_TABLE: begin
              if (avm.readdata != table_q[index]) begin
                next_state = LD_IDLE;
                next_index = '0;
                issue_c    = 1'b0;
                error_d    = 1'b1;
              end else if (last_index_c) begin
                next_index = '0;
                next_state = LD_WR_TIPO;
              end else begin
                next_index = index + IDX_W'(1);
              end
            end
`endif
            LD_WR_TIPO:   next_state = LD_WR_ENABLE;
            LD_WR_ENABLE: next_state = LD_WR_START;
            LD_WR_START: begin
              next_state = LD_DONE;
              issue_c    = 1'b0;
            end
            default: begin
              next_state = LD_IDLE;
              issue_c    = 1'b0;
            end
          endcase
        end
      end
    endcase

    busy_d = (next_state != LD_IDLE) && (next_state != LD_DONE);
    done_d = (next_state == LD_DONE);
  end

  // Transfer payload follows the state being entered.
  always_comb begin
    issue_read_c      = 1'b0;
    issue_address_c   = '0;
    issue_writedata_c = '0;
    unique case (next_state)
      LD_WR_TABLE: begin
        issue_address_c   = ADDR_W'(ADDR_STEP_BASE) + ADDR_W'(next_index);
        issue_writedata_c = table_d[next_index];
      end
`ifdef DDS_LOADER_VERIFY_EN
      LD_RD_TABLE: begin
        issue_read_c    = 1'b1;
        issue_address_c = ADDR_W'(ADDR_STEP_BASE) + ADDR_W'(next_index);
      end
`endif
      LD_WR_TIPO: begin
        issue_address_c   = ADDR_W'(ADDR_TIPO);
        issue_writedata_c = DATA_W'(tipo_d);
      end
      LD_WR_ENABLE: begin
        issue_address_c   = ADDR_W'(ADDR_ENABLE);
        issue_writedata_c = DATA_W'(enable_d);
      end
      LD_WR_START: begin
        issue_address_c   = ADDR_W'(ADDR_START);
        issue_writedata_c = DATA_W'(1);
      end
      default: begin
        issue_address_c   = '0;
        issue_writedata_c = '0;
      end
    endcase
  end

  dds_avm_xfer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) u_xfer (
    .clock             (clock),
    .reset             (reset),
    .issue_c           (issue_c),
    .issue_read_c      (issue_read_c),
    .issue_address_c   (issue_address_c),
    .issue_writedata_c (issue_writedata_c),
    .xfer_done_c       (xfer_done_c),
    .xfer_timeout_c    (xfer_timeout_c),
    .bus               (avm)
  );

endmodule

// File: tb/tb_dds_avalon_mm_loader.sv
// Self-checking bench for dds_avalon_mm_loader: Avalon slave model with per-address stalls,
// and a transfer-list reference model (honours DDS_LOADER_VERIFY_EN).
`timescale 1ns/1ps
module tb_dds_avalon_mm_loader;

  localparam int unsigned N_STEPS = 16;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 255;
`ifdef DDS_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef logic [N_STEPS-1:0][DATA_W-1:0] table_t;

  logic   clock = 1'b0;
  logic   reset;
  logic   i_go;
  table_t i_step_table;
  logic   i_enable;
  logic   i_tipo_ajuste;
  logic   o_busy;
  logic   o_done;
  logic   o_error;

  dds_avalon_mm_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm_bus ();

  dds_avalon_mm_loader #(
    .N_STEPS (N_STEPS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_go          (i_go),
    .i_step_table  (i_step_table),
    .i_enable      (i_enable),
    .i_tipo_ajuste (i_tipo_ajuste),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .avm           (avm_bus)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Slave model state and observations for the current run.
  int unsigned       stall_plan [32];
  int                stuck_addr = -1;
  int                corrupt_addr = -1;
  logic [DATA_W-1:0] mem [32];
  bit                active = 1'b0;
  int unsigned       left = 0;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [DATA_W-1:0] wr_data_q [$];
  int unsigned       rd_cnt = 0;
  int unsigned       done_cnt = 0;
  int unsigned       done_cyc = 0;
  bit                err_seen = 1'b0;
  int unsigned       err_cyc = 0;
  int unsigned       go_cyc = 0;

  always @(negedge clock) begin
    if (reset) begin
      active = 1'b0;
      avm_bus.waitrequest = 1'b0;
      avm_bus.readdata = '0;
    end else begin
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_error && !err_seen && cyc > go_cyc) begin
        err_seen = 1'b1;
        err_cyc = cyc;
      end
      if (avm_bus.chipselect) begin
        if (!active) begin
          active    = 1'b1;
          left      = stall_plan[avm_bus.address];
          held_addr = avm_bus.address;
          held_data = avm_bus.writedata;
        end else begin
          check_val("hold_addr", 64'(avm_bus.address), 64'(held_addr));
          check_val("hold_data", 64'(avm_bus.writedata), 64'(held_data));
        end
        if (left > 0) begin
          left--;
          avm_bus.waitrequest = 1'b1;
        end else begin
          avm_bus.waitrequest = 1'b0;
          active = 1'b0;
          if (avm_bus.write) begin
            wr_addr_q.push_back(avm_bus.address);
            wr_data_q.push_back(avm_bus.writedata);
            mem[avm_bus.address] = avm_bus.writedata;
          end else if (avm_bus.read) begin
            rd_cnt++;
            avm_bus.readdata = (int'(avm_bus.address) == corrupt_addr) ?
                               (mem[avm_bus.address] ^ 32'h0000_0100) : mem[avm_bus.address];
          end
        end
      end else begin
        active = 1'b0;
        avm_bus.waitrequest = 1'b0;
      end
    end
  end

  task automatic clear_plan();
    for (int a = 0; a < 32; a++) stall_plan[a] = 0;
    stuck_addr = -1;
    corrupt_addr = -1;
  endtask

  task automatic start_go(input table_t tbl, input logic en, input logic tp);
    @(negedge clock);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_cnt = 0;
    done_cnt = 0;
    err_seen = 1'b0;
    go_cyc = cyc;
    i_step_table  = tbl;
    i_enable      = en;
    i_tipo_ajuste = tp;
    i_go = 1'b1;
    @(negedge clock);
    i_go = 1'b0;
  endtask

  // Wait for the sequence to end, then compare against the expected transfer list.
  task automatic finish_and_check(input string name, input table_t tbl, input logic en, input logic tp);
    bit                expired = 1'b1;
    bit                exp_ok  = 1'b1;
    int unsigned       stalls  = 0;
    int unsigned       exp_end = 0;
    int unsigned       n;
    logic [ADDR_W-1:0] ea [$];
    logic [DATA_W-1:0] ed [$];

    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (!o_busy) begin
        expired = 1'b0;
        break;
      end
    end
    check_val({name, ":timeout_wait"}, 64'(expired), 64'(0));
    repeat (2) @(negedge clock);

    for (int i = 0; i < int'(N_STEPS); i++) begin
      if (stuck_addr == i) begin
        exp_ok  = 1'b0;
        exp_end = 1 + i + stalls + TIMEOUT;
        break;
      end
      ea.push_back(ADDR_W'(i));
      ed.push_back(tbl[i]);
      stalls += stall_plan[i];
    end
    if (exp_ok && VERIFY) begin
      for (int i = 0; i < int'(N_STEPS); i++) begin
        if (corrupt_addr == i) begin
          exp_ok  = 1'b0;
          exp_end = 2 + N_STEPS + i + stalls + stall_plan[i];
          break;
        end
        stalls += stall_plan[i];
      end
    end
    if (exp_ok) begin
      ea.push_back(ADDR_W'(17)); ed.push_back(DATA_W'(tp));
      ea.push_back(ADDR_W'(16)); ed.push_back(DATA_W'(en));
      ea.push_back(ADDR_W'(18)); ed.push_back(DATA_W'(1));
      stalls += stall_plan[17] + stall_plan[16] + stall_plan[18];
      exp_end = N_STEPS + 4 + (VERIFY ? N_STEPS : 0) + stalls;
    end

    check_val({name, ":wr_count"}, 64'(wr_addr_q.size()), 64'(ea.size()));
    n = (wr_addr_q.size() < ea.size()) ? wr_addr_q.size() : ea.size();
    for (int i = 0; i < int'(n); i++) begin
      check_val({name, ":wr_addr"}, 64'(wr_addr_q[i]), 64'(ea[i]));
      check_val({name, ":wr_data"}, 64'(wr_data_q[i]), 64'(ed[i]));
    end
    check_val({name, ":busy_end"}, 64'(o_busy), 64'(0));
    check_val({name, ":cs_end"}, 64'(avm_bus.chipselect), 64'(0));
    check_val({name, ":error"}, 64'(o_error), exp_ok ? 64'(0) : 64'(1));
    if (exp_ok) begin
      check_val({name, ":done_count"}, 64'(done_cnt), 64'(1));
      check_val({name, ":done_latency"}, 64'(done_cyc - go_cyc), 64'(exp_end));
      check_val({name, ":rd_count"}, 64'(rd_cnt), VERIFY ? 64'(N_STEPS) : 64'(0));
    end else begin
      check_val({name, ":done_count"}, 64'(done_cnt), 64'(0));
      check_val({name, ":error_latency"}, 64'(err_cyc - go_cyc), 64'(exp_end));
    end
  endtask

  task automatic run_seq(input string name, input table_t tbl, input logic en, input logic tp);
    start_go(tbl, en, tp);
    finish_and_check(name, tbl, en, tp);
  endtask

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: bench did not finish (got running, expected finished)");
    $fatal(1, "watchdog");
  end

  initial begin
    table_t tbl, tbl2;

    reset = 1'b1;
    i_go = 1'b0;
    i_step_table = '0;
    i_enable = 1'b0;
    i_tipo_ajuste = 1'b0;
    clear_plan();
    for (int a = 0; a < 32; a++) mem[a] = '0;
    repeat (3) @(negedge clock);

    check_val("rst_cs", 64'(avm_bus.chipselect), 64'(0));
    check_val("rst_write", 64'(avm_bus.write), 64'(0));
    check_val("rst_read", 64'(avm_bus.read), 64'(0));
    check_val("rst_addr", 64'(avm_bus.address), 64'(0));
    check_val("rst_wdata", 64'(avm_bus.writedata), 64'(0));
    check_val("rst_busy", 64'(o_busy), 64'(0));
    check_val("rst_done", 64'(o_done), 64'(0));
    check_val("rst_error", 64'(o_error), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < int'(N_STEPS); i++) tbl[i] = 32'h1000_0000 + 32'(i);
    run_seq("nostall", tbl, 1'b1, 1'b0);

    stall_plan[5] = 3;
    run_seq("stall5", tbl, 1'b0, 1'b1);
    clear_plan();

    stall_plan[18] = 4;
    run_seq("stall_start", tbl, 1'b1, 1'b1);
    clear_plan();

    stuck_addr = 2;
    stall_plan[2] = 100000;
    run_seq("timeout2", tbl, 1'b1, 1'b0);
    clear_plan();

    for (int i = 0; i < int'(N_STEPS); i++) tbl[i] = $urandom;
    run_seq("after_timeout", tbl, 1'b1, 1'b0);

    // A second go mid-sequence must not disturb the first capture.
    for (int i = 0; i < int'(N_STEPS); i++) tbl2[i] = ~tbl[i];
    start_go(tbl, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    i_step_table = tbl2;
    i_enable = 1'b0;
    i_tipo_ajuste = 1'b0;
    i_go = 1'b1;
    @(negedge clock);
    i_go = 1'b0;
    finish_and_check("ignored_go", tbl, 1'b1, 1'b1);

    // Reset in the middle of the table load.
    start_go(tbl, 1'b1, 1'b0);
    repeat (6) @(negedge clock);
    reset = 1'b1;
    #1;
    check_val("midrst_cs", 64'(avm_bus.chipselect), 64'(0));
    check_val("midrst_write", 64'(avm_bus.write), 64'(0));
    check_val("midrst_busy", 64'(o_busy), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_val("midrst_idle_cs", 64'(avm_bus.chipselect), 64'(0));
    run_seq("after_reset", tbl2, 1'b0, 1'b1);

    // Read-back corruption: only aborts when read-back checking is built in.
    corrupt_addr = 9;
    run_seq("corrupt9", tbl, 1'b1, 1'b1);
    clear_plan();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'(N_STEPS); i++) tbl[i] = $urandom;
      for (int a = 0; a < 32; a++)
        stall_plan[a] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_seq("random", tbl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      clear_plan();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
